// File: rtl/trivium_stream_ctrl_pkg.sv
// Shared types and widths for the trivium stream controller.
// Holds the controller state encoding and the fixed key/IV/counter widths.
// Also holds a saturating increment helper used by the word counter.
package trivium_ctrl_pkg;

  localparam int KEY_W = 80;
  localparam int IV_W  = 80;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_CORE = 3'd1,
    WAIT_WORD  = 3'd2,
    ADVANCE    = 3'd3,
    DRAIN      = 3'd4,
    ERROR      = 3'd5
  } state_t;

  // Counts up but sticks at all-ones so an endless session never wraps to 0.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trivium_stream_ctrl_if.sv
// Keystream output channel: one word per cycle when ks_valid & ks_ready.
// Ports: ks_data (word), ks_valid (word present), ks_ready (sink accepts).
// master = controller side, slave = downstream consumer.
interface trivium_stream_ctrl_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic [DATA_WIDTH-1:0] ks_data;
  logic                  ks_valid;
  logic                  ks_ready;

  modport master (output ks_data, output ks_valid, input ks_ready);
  modport slave  (input ks_data, input ks_valid, output ks_ready);

endinterface

// File: rtl/trivium_stream_ctrl_ks_fifo2.sv
// Two-entry keystream buffer with a registered head word.
// Ports: push/push_dat in, pop/flush in, full/empty/head out. Latency: a pushed
// word is on head one cycle later. Backpressure: full (pre-pop count) blocks push.
module ks_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         do_pop, do_push;
  logic [1:0]   cnt_after_pop;

  always_comb begin
    cnt_d         = cnt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    do_pop        = pop && (cnt_q != 2'd0);
    // A pop in the same cycle frees the slot, so push into a full buffer is legal then.
    do_push       = push && ((cnt_q != 2'd2) || do_pop);
    cnt_after_pop = cnt_q - {1'b0, do_pop};

    if (flush) begin
      // Head word is left in place so ks_data keeps its last value.
      cnt_d = 2'd0;
    end else begin
      if (do_pop && (cnt_q == 2'd2)) begin
        head_d = tail_q;
      end
      if (do_push) begin
        if (cnt_after_pop == 2'd0) begin
          head_d = push_dat;
        end else begin
          tail_d = push_dat;
        end
      end
      cnt_d = cnt_after_pop + {1'b0, do_push};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = head_q;

endmodule

// File: rtl/trivium_stream_ctrl.sv
// Sequences a trivium core: latch key/IV, hold core in reset, pull num_blocks words.
// Ports: start/abort/key/iv/num_blocks in; busy/done/err/blk_count out; ks (master
// keystream channel); core_* to the cipher core. Latency: word on ks one cycle after
// capture. Backpressure: 2-entry buffer; when full the FSM stalls and stops advancing.
module trivium_stream_ctrl
  import trivium_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [KEY_W-1:0]      key,
  input  logic [IV_W-1:0]       iv,
  input  logic [CNT_W-1:0]      num_blocks,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      blk_count,
  trivium_stream_ctrl_if.master ks,
  output logic                  core_rst,
  output logic [KEY_W-1:0]      core_key,
  output logic [IV_W-1:0]       core_iv,
  output logic                  core_next,
  input  logic                  core_end,
  input  logic [DATA_WIDTH-1:0] core_block
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IV_W-1:0]  iv_q, iv_d;
  logic [CNT_W-1:0] nblk_q, nblk_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic             err_q, err_d;

  logic fifo_push, fifo_flush, fifo_full, fifo_empty, fifo_pop;
  logic next_o, done_o;

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    wd_d       = wd_q;
    key_d      = key_q;
    iv_d       = iv_q;
    nblk_d     = nblk_q;
    blk_d      = blk_q;
    err_d      = err_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    next_o     = 1'b0;
    done_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          key_d     = key;
          iv_d      = iv;
          nblk_d    = num_blocks;
          blk_d     = '0;
          err_d     = 1'b0;
          rst_cnt_d = '0;
          state_d   = RESET_CORE;
        end
      end
      RESET_CORE: begin
        if (rst_cnt_q == RC_LAST) begin
          wd_d    = '0;
          state_d = WAIT_WORD;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      WAIT_WORD: begin
        if (core_end) begin
          // Word ready but buffer full: hold here with the watchdog frozen.
          if (!fifo_full) begin
            fifo_push = 1'b1;
            blk_d     = sat_inc(blk_q);
            state_d   = ADVANCE;
          end
        end else if (wd_q == WD_LAST) begin
          err_d      = 1'b1;
          fifo_flush = 1'b1;
          state_d    = ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ADVANCE: begin
        // core_end is still high from the word just taken; it is not looked at here.
        if ((nblk_q != '0) && (blk_q == nblk_q)) begin
          state_d = DRAIN;
        end else begin
          next_o  = 1'b1;
          wd_d    = '0;
          state_d = WAIT_WORD;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      ERROR: begin
        fifo_flush = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort dominates everything the state logic decided this cycle.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      blk_d      = blk_q;
      err_d      = err_q;
      next_o     = 1'b0;
      done_o     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      wd_q      <= '0;
      key_q     <= '0;
      iv_q      <= '0;
      nblk_q    <= '0;
      blk_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      wd_q      <= wd_d;
      key_q     <= key_d;
      iv_q      <= iv_d;
      nblk_q    <= nblk_d;
      blk_q     <= blk_d;
      err_q     <= err_d;
    end
  end

  ks_fifo2 #(.W(DATA_WIDTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (core_block),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (ks.ks_data)
  );

  assign ks.ks_valid = !fifo_empty;
  assign fifo_pop    = !fifo_empty && ks.ks_ready;

  assign busy      = state_q inside {RESET_CORE, WAIT_WORD, ADVANCE, DRAIN};
  assign core_rst  = state_q inside {IDLE, RESET_CORE, ERROR};
  assign done      = done_o;
  assign err       = err_q;
  assign blk_count = blk_q;
  assign core_key  = key_q;
  assign core_iv   = iv_q;
  assign core_next = next_o;

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Bench for trivium_stream_ctrl with a behavioural cipher-core mock.
// Expected keystream words go into a queue at start; a monitor pops on each transfer.
// Mock word k of a session = {core_key[31:0], k}; first word ~18 cycles after core_rst falls.
module tb_trivium_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        start, abort;
  logic [79:0] key_i, iv_i;
  logic [15:0] nb_i;
  logic        busy, done, err;
  logic [15:0] blk_count;
  logic        core_rst, core_next, core_end;
  logic [79:0] core_key, core_iv;
  logic [63:0] core_block;

  trivium_stream_ctrl_if #(.DATA_WIDTH(64)) ks_if ();

  trivium_stream_ctrl #(.DATA_WIDTH(64), .RST_CYCLES(2), .TIMEOUT(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .key        (key_i),
    .iv         (iv_i),
    .num_blocks (nb_i),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .blk_count  (blk_count),
    .ks         (ks_if),
    .core_rst   (core_rst),
    .core_key   (core_key),
    .core_iv    (core_iv),
    .core_next  (core_next),
    .core_end   (core_end),
    .core_block (core_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int next_cnt = 0;
  int mon_cnt  = 0;
  logic [63:0] exp_q[$];

  // ---------------- core mock ----------------
  logic        mock_en;
  int unsigned dly;
  logic [31:0] widx;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_end   <= 1'b0;
      core_block <= '0;
      dly        <= 0;
      widx       <= '0;
    end else if (core_rst) begin
      core_end <= 1'b0;
      widx     <= '0;
      dly      <= 18;
    end else if (core_next) begin
      core_end <= 1'b0;
      widx     <= widx + 1;
      dly      <= 3;
    end else if (!core_end && mock_en) begin
      if (dly <= 1) begin
        core_end   <= 1'b1;
        core_block <= {core_key[31:0], widx};
      end else begin
        dly <= dly - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst && done)      done_cnt <= done_cnt + 1;
    if (rst && core_next) next_cnt <= next_cnt + 1;
  end

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst && ks_if.ks_valid && ks_if.ks_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ks_unexpected got=%0h want=no word", ks_if.ks_data);
      end else begin
        check("ks_word", {16'h0, ks_if.ks_data}, {16'h0, exp_q.pop_front()});
        mon_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] rand80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  task automatic do_start(input logic [79:0] k, input logic [79:0] v,
                          input logic [15:0] nb, input int n_exp);
    key_i = k;
    iv_i  = v;
    nb_i  = nb;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < n_exp; j++) exp_q.push_back({k[31:0], 32'(j)});
  endtask

  task automatic wait_done(input string nm, input int budget, input bit rnd_rdy,
                           input logic [15:0] exp_blk);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < budget) begin
      if (rnd_rdy) ks_if.ks_ready = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    ks_if.ks_ready = 1'b1;
    check({nm, "_done_count"}, 80'(done_cnt - d0), 80'd1);
    check({nm, "_blk_count"}, {64'h0, blk_count}, {64'h0, exp_blk});
    check({nm, "_queue_left"}, 80'(exp_q.size()), 80'd0);
    check({nm, "_busy"}, {79'h0, busy}, 80'd0);
    check({nm, "_err"}, {79'h0, err}, 80'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_busy"}, {79'h0, busy}, 80'd0);
    check({nm, "_done"}, {79'h0, done}, 80'd0);
    check({nm, "_err"}, {79'h0, err}, 80'd0);
    check({nm, "_ks_valid"}, {79'h0, ks_if.ks_valid}, 80'd0);
    check({nm, "_blk_count"}, {64'h0, blk_count}, 80'd0);
    check({nm, "_ks_data"}, {16'h0, ks_if.ks_data}, 80'd0);
    check({nm, "_core_rst"}, {79'h0, core_rst}, 80'd1);
    check({nm, "_core_key"}, core_key, 80'd0);
    check({nm, "_core_iv"}, core_iv, 80'd0);
    check({nm, "_core_next"}, {79'h0, core_next}, 80'd0);
  endtask

  initial begin
    logic [79:0] k1, k2, k3;
    logic [15:0] nb;
    int n0, d0, m0, i;

    rst = 1'b0; start = 1'b0; abort = 1'b0; mock_en = 1'b1;
    key_i = '0; iv_i = '0; nb_i = '0; ks_if.ks_ready = 1'b0;
    #13;
    check_reset_vals("reset");
    rst = 1'b1;
    tick();

    // 4 words, sink always ready
    ks_if.ks_ready = 1'b1;
    k1 = rand80();
    do_start(k1, rand80(), 16'd4, 4);
    check("start_key_latched", core_key, k1);
    wait_done("nb4", 300, 1'b0, 16'd4);
    check("nb4_core_rst_after", {79'h0, core_rst}, 80'd1);

    // 3 words, sink stalled 40 cycles: two buffered, FSM holds the third
    ks_if.ks_ready = 1'b0;
    n0 = next_cnt;
    do_start(rand80(), rand80(), 16'd3, 3);
    repeat (40) tick();
    check("stall_ks_valid", {79'h0, ks_if.ks_valid}, 80'd1);
    check("stall_core_next_count", 80'(next_cnt - n0), 80'd2);
    check("stall_blk_count", {64'h0, blk_count}, 80'd2);
    check("stall_busy", {79'h0, busy}, 80'd1);
    check("stall_err", {79'h0, err}, 80'd0);
    ks_if.ks_ready = 1'b1;
    wait_done("stall_release", 300, 1'b0, 16'd3);

    // random sessions with a randomly toggling sink
    for (int s = 0; s < 4; s++) begin
      nb = 16'($urandom_range(1, 6));
      do_start(rand80(), rand80(), nb, int'(nb));
      wait_done("rand_sess", 600, 1'b1, nb);
    end

    // watchdog: the core never produces a word
    mock_en = 1'b0;
    do_start(rand80(), rand80(), 16'd2, 0);
    i = 1;
    while (!err && i < 300) begin
      tick();
      if (!err) i++;
    end
    total++;
    if (!(i >= 101 && i <= 103)) begin
      bad++;
      $display("FAIL wd_timeout_cycle got=%0d want=101..103", i);
    end
    check("wd_core_rst_in_error", {79'h0, core_rst}, 80'd1);
    tick();
    check("wd_busy_after", {79'h0, busy}, 80'd0);
    check("wd_err_sticky", {79'h0, err}, 80'd1);
    check("wd_core_rst_after", {79'h0, core_rst}, 80'd1);
    check("wd_ks_valid", {79'h0, ks_if.ks_valid}, 80'd0);
    mock_en = 1'b1;
    do_start(rand80(), rand80(), 16'd1, 1);
    check("err_cleared_by_start", {79'h0, err}, 80'd0);
    wait_done("after_wd", 300, 1'b0, 16'd1);

    // abort mid-stream, with a start in the same cycle
    k1 = rand80();
    k2 = ~k1;
    d0 = done_cnt;
    m0 = mon_cnt;
    do_start(k1, rand80(), 16'd0, 16);
    i = 0;
    while (mon_cnt < m0 + 2 && i < 300) begin
      tick();
      i++;
    end
    check("abort_words_seen", 80'(mon_cnt >= m0 + 2), 80'd1);
    key_i = k2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    exp_q.delete();
    check("abort_ks_valid", {79'h0, ks_if.ks_valid}, 80'd0);
    check("abort_busy", {79'h0, busy}, 80'd0);
    check("abort_core_rst", {79'h0, core_rst}, 80'd1);
    check("abort_core_key", core_key, k1);
    repeat (5) tick();
    check("abort_start_ignored", {79'h0, busy}, 80'd0);
    check("abort_no_done", 80'(done_cnt - d0), 80'd0);

    // start while busy is ignored; then an async reset mid-session
    k2 = rand80();
    k3 = ~k2;
    do_start(k2, rand80(), 16'd5, 5);
    repeat (3) tick();
    key_i = k3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_key_kept", core_key, k2);
    check("busy_start_busy", {79'h0, busy}, 80'd1);
    repeat (25) tick();
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    exp_q.delete();
    #3;
    rst = 1'b1;
    tick();

    // recovery after reset
    do_start(rand80(), rand80(), 16'd2, 2);
    wait_done("recover", 300, 1'b1, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
